// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Resolution side of the branch predictor. Each prediction issued at IF is
// recorded in a small in-order queue. When ID resolves a branch, the actual
// outcome is compared with the oldest recorded prediction. The unit then
// drives the predictor training strobe, a one-cycle fetch redirect and a
// multi-cycle flush whenever the prediction was wrong.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   i_pred_*             prediction issued at IF (valid, pc, taken, target)
//   i_res_*              branch resolved at ID (valid, pc, taken, target)
//   o_upd_*              predictor training (valid, taken, target)
//   o_redirect_*         one-cycle fetch redirect with the corrected PC
//   o_flush              kill younger in-flight instructions
//   o_full               queue full, so IF must stall branch issue
//   o_mispredict_cnt     saturating mispredict count
//   o_resolve_cnt        saturating resolved-branch count
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_RUN   | normal operation: record predictions, resolve branches
// S_FLUSH | o_flush held; IF and ID inputs ignored; down-counter runs

module branch_resolve_unit #(
    parameter int N            = 32,
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_pred_valid,
    input  logic [N-1:0]     i_pred_pc,
    input  logic             i_pred_taken,
    input  logic [N-1:0]     i_pred_target,
    input  logic             i_res_valid,
    input  logic [N-1:0]     i_res_pc,
    input  logic             i_res_taken,
    input  logic [N-1:0]     i_res_target,
    output logic             o_upd_valid,
    output logic             o_upd_taken,
    output logic [N-1:0]     o_upd_target,
    output logic             o_redirect_valid,
    output logic [N-1:0]     o_redirect_pc,
    output logic             o_flush,
    output logic             o_full,
    output logic [CNT_W-1:0] o_mispredict_cnt,
    output logic [CNT_W-1:0] o_resolve_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    logic [0:0]    state;
    logic [FW-1:0] flush_cnt;

    logic [N-1:0]  q_pc     [DEPTH];
    logic          q_taken  [DEPTH];
    logic [N-1:0]  q_target [DEPTH];

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    logic          in_run;
    logic          empty;
    logic          full;
    logic [N-1:0]  head_pc;
    logic          head_taken;
    logic [N-1:0]  head_target;
    logic          res_act;
    logic          hit;
    logic          pop;
    logic          push;
    logic          mispred;
    logic [N-1:0]  redir_pc;

    always_comb begin
        in_run      = (state == S_RUN);
        empty       = (wptr == rptr);
        // Same slot, different lap: writer is a full queue ahead of reader.
        full        = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
        head_pc     = q_pc[rptr[AW-1:0]];
        head_taken  = q_taken[rptr[AW-1:0]];
        head_target = q_target[rptr[AW-1:0]];
        res_act     = in_run && i_res_valid;
        hit         = !empty && (head_pc == i_res_pc);
        pop         = res_act && hit;
        // A resolve with no matching head counts as a not-taken prediction.
        if (hit) begin
            mispred = res_act && ((head_taken != i_res_taken) ||
                                  (head_taken && i_res_taken && (head_target != i_res_target)));
        end else begin
            mispred = res_act && i_res_taken;
        end
        // A pop frees a slot in the same cycle, so a full queue still accepts.
        push        = in_run && i_pred_valid && (!full || pop);
        redir_pc    = i_res_taken ? i_res_target : (i_res_pc + N'(4));
        o_full      = full && in_run;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wptr[AW-1:0]]     <= i_pred_pc;
            q_taken[wptr[AW-1:0]]  <= i_pred_taken;
            q_target[wptr[AW-1:0]] <= i_pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_RUN;
            flush_cnt        <= '0;
            wptr             <= '0;
            rptr             <= '0;
            o_upd_valid      <= 1'b0;
            o_upd_taken      <= 1'b0;
            o_upd_target     <= '0;
            o_redirect_valid <= 1'b0;
            o_redirect_pc    <= '0;
            o_flush          <= 1'b0;
            o_mispredict_cnt <= '0;
            o_resolve_cnt    <= '0;
        end else begin
            o_upd_valid      <= res_act;
            o_upd_taken      <= res_act && i_res_taken;
            o_upd_target     <= res_act ? i_res_target : '0;
            o_redirect_valid <= mispred;
            o_redirect_pc    <= mispred ? redir_pc : '0;

            if (res_act && (o_resolve_cnt != '1)) begin
                o_resolve_cnt <= o_resolve_cnt + CNT_W'(1);
            end
            if (mispred && (o_mispredict_cnt != '1)) begin
                o_mispredict_cnt <= o_mispredict_cnt + CNT_W'(1);
            end

            case (state)
                S_RUN: begin
                    if (mispred) begin
                        // Everything still queued is on the wrong path,
                        // including a prediction arriving this cycle.
                        state     <= S_FLUSH;
                        o_flush   <= 1'b1;
                        flush_cnt <= FW'(FLUSH_CYCLES - 1);
                        wptr      <= '0;
                        rptr      <= '0;
                    end else begin
                        if (push) wptr <= wptr + PW'(1);
                        if (pop)  rptr <= rptr + PW'(1);
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt == '0) begin
                        state   <= S_RUN;
                        o_flush <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - FW'(1);
                    end
                end
                default: begin
                    state   <= S_RUN;
                    o_flush <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Resolution-side counterpart of the branch predictor. Records every prediction issued at IF in a small in-order queue. When ID resolves a branch, compares the actual outcome with the recorded prediction. Drives the predictor-training signals (taken, target), a one-cycle redirect with the correct PC, and a multi-cycle pipeline flush on misprediction.

Parameters:
N, 32, datapath/PC width
DEPTH, 4, in-flight prediction queue entries (power of 2, >=2)
FLUSH_CYCLES, 2, cycles o_flush is held after a misprediction (>=1)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
i_pred_valid  in  1  IF issued a prediction for a branch this cycle
i_pred_pc  in  N  PC of predicted branch
i_pred_taken  in  1  predicted direction
i_pred_target  in  N  predicted target (ignored when i_pred_taken=0)
i_res_valid  in  1  ID resolved a branch this cycle
i_res_pc  in  N  PC of resolved branch
i_res_taken  in  1  actual direction
i_res_target  in  N  actual taken target
o_upd_valid  out  1  predictor training strobe
o_upd_taken  out  1  actual direction to predictor
o_upd_target  out  N  actual target to predictor
o_redirect_valid  out  1  one-cycle fetch redirect
o_redirect_pc  out  N  corrected fetch PC
o_flush  out  1  kill younger in-flight instructions
o_full  out  1  queue full; IF must stall branch issue
o_mispredict_cnt  out  CNT_W  saturating mispredict count
o_resolve_cnt  out  CNT_W  saturating resolved-branch count

Behaviour:
- Reset (rst_n=0 at posedge): queue empty, FSM=RUN, every output 0, counters 0. Reset mid-flush aborts the flush immediately.
- Queue: circular FIFO; fields {pc, taken, target}. Read/write pointers are log2(DEPTH)+1 bits; full/empty are derived from pointer MSB plus equality; pointers wrap modulo DEPTH.
- Push: i_pred_valid in RUN and not full. A push while full is dropped and leaves the queue unchanged. When the queue is full, a push and a pop in the same cycle both take effect.
- Resolve, in RUN only, when i_res_valid=1:
  * Head match: queue non-empty and head.pc==i_res_pc. Pop the head.
  * Mispredict when taken differs, or when both taken and head.target!=i_res_target.
  * Orphan: queue empty or head.pc mismatch. Treat as a prediction of not-taken and do not pop. Orphan mispredicts only if i_res_taken=1.
- All outputs are registered. Latency from i_res_valid to outputs is 1 cycle.
  * o_upd_valid=1 for every resolve in RUN. o_upd_taken=i_res_taken. o_upd_target=i_res_target.
  * On mispredict: o_redirect_valid=1 for exactly 1 cycle. o_redirect_pc = i_res_taken ? i_res_target : i_res_pc+4, mod 2^N.
- FSM:
  * RUN -> FLUSH when a resolve mispredicts. In that same edge the whole queue is cleared, including any same-cycle push.
  * FLUSH: o_flush=1 for FLUSH_CYCLES consecutive cycles, starting in the same cycle as o_redirect_valid. A down-counter loads FLUSH_CYCLES-1.
  * In FLUSH, i_pred_valid and i_res_valid are ignored: no push, no update, no count.
  * FLUSH -> RUN when the counter reaches 0.
- o_full is combinational from the pointers and is 0 during FLUSH.
- Counters increment by 1 per resolve or per mispredict and saturate at 2^CNT_W-1.
- o_upd_* and o_redirect_pc hold 0 when their strobe is low.

Test Plan:
- Correct prediction: push {pc=0x100, taken=1, tgt=0x140}; resolve {0x100, 1, 0x140} next cycle. Required: next cycle o_upd_valid=1, o_upd_taken=1, o_upd_target=0x140, no redirect, no flush; queue empty; resolve_cnt=1, mispredict_cnt=0.
- Direction mispredict: push {0x200, 0, x}; resolve {0x200, 1, 0x80}. Required: next cycle o_redirect_valid=1, pc=0x80; o_flush high for 2 cycles; mispredict_cnt=1; pushes during flush are dropped, so the queue is still empty afterwards.
- Target mispredict and not-taken redirect: push {0x300, 1, 0x400}; resolve {0x300, 1, 0x500} gives redirect_pc=0x500. Push {0x304, 1, 0x10}; resolve {0x304, 0, x} gives redirect_pc=0x308.
- Full queue: push 4 predictions with no resolve, so o_full=1; a 5th push is dropped. Then push and resolve-head in the same cycle: count stays 4 and FIFO order is preserved through a pointer wrap.
- Orphan: with the queue empty, resolve {0x600, 0} gives update only with no redirect; resolve {0x600, 1, 0x700} gives redirect_pc=0x700, flush, and no pop.
- Reset mid-flush: assert rst_n=0 in the 1st flush cycle. Required: next cycle o_flush=0, all outputs 0, counters 0, queue empty.
